// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the serial adder controller.
// Optional subtract support is selected with the SERIAL_ADDER_SUB_EN macro.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WORD_DEF  = 2;
    localparam int WORDS_DEF = 4;

    // Slice index width; a single-slice build still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_width(WORDS_DEF);

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// io_in_sub only exists when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WORD  = WORD_DEF,
    parameter int WORDS = WORDS_DEF
);
    localparam int W = WORD * WORDS;

    logic         io_in_valid;
    logic         io_in_ready;
    logic [W-1:0] io_in_lhs;
    logic [W-1:0] io_in_rhs;
    logic         io_in_cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic         io_in_sub;
`endif
    logic         io_out_valid;
    logic         io_out_ready;
    logic [W-1:0] io_out_sum;
    logic         io_out_cout;
    logic         io_busy;

    // Producer/consumer side
    modport master (
        output io_in_valid, io_in_lhs, io_in_rhs, io_in_cin,
`ifdef SERIAL_ADDER_SUB_EN
        output io_in_sub,
`endif
        output io_out_ready,
        input  io_in_ready, io_out_valid, io_out_sum, io_out_cout, io_busy
    );

    // Controller side
    modport slave (
        input  io_in_valid, io_in_lhs, io_in_rhs, io_in_cin,
`ifdef SERIAL_ADDER_SUB_EN
        input  io_in_sub,
`endif
        input  io_out_ready,
        output io_in_ready, io_out_valid, io_out_sum, io_out_cout, io_busy
    );

endinterface

// File: rtl/serial_adder_ctrl_adder.sv
// Narrow WORD-bit adder slice with carry in/out; purely combinational.
module Adder #(
    parameter int WORD = 2
) (
    input  logic            io_cin,
    input  logic [WORD-1:0] io_lhs,
    input  logic [WORD-1:0] io_rhs,
    output logic [WORD-1:0] io_out,
    output logic            io_cout
);

    assign {io_cout, io_out} = {1'b0, io_lhs} + {1'b0, io_rhs} + {{WORD{1'b0}}, io_cin};

endmodule

// File: rtl/serial_adder_ctrl.sv
// Serial wide adder: one WORD-bit slice per cycle, carry rippling across cycles.
// SERIAL_ADDER_SUB_EN adds a subtract mode (rhs inverted, carry-in forced to 1).
//
// state | meaning
// IDLE  | waiting for operands, io_in_ready high
// BUSY  | slice idx being added this cycle
// DONE  | result presented until the consumer takes it
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WORD  = WORD_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input logic               clk,
    input logic               reset,
    serial_adder_ctrl_if.slave bus
);

    localparam int IDXW = idx_width(WORDS);
    localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

    state_t                     state;
    logic [IDXW-1:0]            idx;
    logic [WORDS-1:0][WORD-1:0] lhs_q;
    logic [WORDS-1:0][WORD-1:0] rhs_q;
    logic [WORDS-1:0][WORD-1:0] sum_q;
    logic                       carry;
    logic                       cout_q;
    logic                       valid_q;
    logic                       busy_q;
`ifdef SERIAL_ADDER_SUB_EN
    logic                       sub_q;
`endif

    logic            in_ready;
    logic            accept;
    logic            cin_init;
    logic [WORD-1:0] slice_rhs;
    logic [WORD-1:0] slice_out;
    logic            slice_cout;

    // Ready depends only on state and consumer ready, never on io_in_valid.
    assign in_ready = (state == IDLE) || ((state == DONE) && bus.io_out_ready);
    assign accept   = bus.io_in_valid && in_ready;

    assign bus.io_in_ready  = in_ready;
    assign bus.io_out_valid = valid_q;
    assign bus.io_out_sum   = sum_q;
    assign bus.io_out_cout  = cout_q;
    assign bus.io_busy      = busy_q;

    // Select the current rhs slice and the carry seeded on accept.
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        slice_rhs = sub_q ? ~rhs_q[idx] : rhs_q[idx];
        cin_init  = bus.io_in_sub | bus.io_in_cin;
`else
        slice_rhs = rhs_q[idx];
        cin_init  = bus.io_in_cin;
`endif
    end

    Adder #(.WORD(WORD)) u_slice (
        .io_cin (carry),
        .io_lhs (lhs_q[idx]),
        .io_rhs (slice_rhs),
        .io_out (slice_out),
        .io_cout(slice_cout)
    );

    // Sequencer: capture on accept, one slice per BUSY cycle, hold in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            lhs_q   <= '0;
            rhs_q   <= '0;
            sum_q   <= '0;
            carry   <= 1'b0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else if (accept) begin
            state   <= BUSY;
            idx     <= '0;
            lhs_q   <= bus.io_in_lhs;
            rhs_q   <= bus.io_in_rhs;
            sum_q   <= '0;
            carry   <= cin_init;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= bus.io_in_sub;
`endif
        end else begin
            case (state)
                IDLE: ;
                BUSY: begin
                    sum_q[idx] <= slice_out;
                    carry      <= slice_cout;
                    if (idx == LAST) begin
                        state   <= DONE;
                        idx     <= '0;
                        cout_q  <= slice_cout;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.io_out_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WORD=2, WORDS=4, W=8).
// Directed cases from the test plan followed by a randomized phase.
module tb_serial_adder_ctrl;

    localparam int WORD  = 2;
    localparam int WORDS = 4;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        int         acc_edge;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t q[$];
    bit   since_reset;

    serial_adder_ctrl_if #(.WORD(WORD), .WORDS(WORDS)) bus ();

    serial_adder_ctrl #(.WORD(WORD), .WORDS(WORDS)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 9-bit arithmetic on whole operands.
    function automatic logic [8:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                          input logic c, input logic s);
        int unsigned r;
        if (s) r = int'(a) + (255 - int'(b)) + 1;
        else   r = int'(a) + int'(b) + int'(c);
        return r[8:0];
    endfunction

    // Monitor/scoreboard: checks control outputs every cycle, data while valid.
    always @(negedge clk) begin
        logic eb, ev, er, s;
        logic [8:0] r;
        if (cyc > 0) begin
            eb = 1'b0;
            ev = 1'b0;
            if (q.size() > 0) begin
                eb = (cyc <  q[0].acc_edge + WORDS);
                ev = (cyc >= q[0].acc_edge + WORDS);
            end
            er = !eb && (!ev || bus.io_out_ready);
            check("ctrl{busy,valid,in_ready}",
                  {29'd0, bus.io_busy, bus.io_out_valid, bus.io_in_ready}, {29'd0, eb, ev, er});
            if (ev) begin
                check("sum", {24'd0, bus.io_out_sum}, {24'd0, q[0].sum});
                check("cout", {31'd0, bus.io_out_cout}, {31'd0, q[0].cout});
            end
            if (since_reset) begin
                check("reset_sum", {24'd0, bus.io_out_sum}, 32'd0);
                check("reset_cout", {31'd0, bus.io_out_cout}, 32'd0);
            end
            if (reset) begin
                q.delete();
                since_reset = 1'b1;
            end else begin
                if (ev && bus.io_out_ready) void'(q.pop_front());
                if (bus.io_in_valid && er) begin
`ifdef SERIAL_ADDER_SUB_EN
                    s = bus.io_in_sub;
`else
                    s = 1'b0;
`endif
                    r = ref_op(bus.io_in_lhs, bus.io_in_rhs, bus.io_in_cin, s);
                    q.push_back('{sum: r[7:0], cout: r[8], acc_edge: cyc + 1});
                    since_reset = 1'b0;
                end
            end
        end else begin
            q.delete();
            since_reset = 1'b1;
        end
    end

    task automatic drive_ops(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
        bus.io_in_lhs = a;
        bus.io_in_rhs = b;
        bus.io_in_cin = c;
`ifdef SERIAL_ADDER_SUB_EN
        bus.io_in_sub = s;
`else
        if (s) $display("[TB] subtract requested in an add-only build");
`endif
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                        output int acc);
        @(posedge clk);
        #1;
        bus.io_in_valid = 1'b1;
        drive_ops(a, b, c, s);
        acc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.io_in_ready) begin
                acc = cyc + 1;
                break;
            end
        end
        if (acc < 0) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.io_in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [7:0] es, input logic ec,
                               input int acc);
        int seen;
        seen = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.io_out_valid) begin
                seen = cyc;
                break;
            end
        end
        if (seen < 0) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, "_sum"}, {24'd0, bus.io_out_sum}, {24'd0, es});
            check({name, "_cout"}, {31'd0, bus.io_out_cout}, {31'd0, ec});
            if (acc >= 0) check({name, "_latency"}, seen - acc, WORDS);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int bad;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        reset   = 1'b1;
        bus.io_in_valid  = 1'b0;
        bus.io_out_ready = 1'b1;
        drive_ops(8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        send(8'h5A, 8'h3C, 1'b0, 1'b0, acc);
        wait_result("add", 8'h96, 1'b0, acc);
        send(8'hFF, 8'h01, 1'b0, 1'b0, acc);
        wait_result("ripple", 8'h00, 1'b1, acc);
        send(8'hFF, 8'h00, 1'b1, 1'b0, acc);
        wait_result("ripple_cin", 8'h00, 1'b1, acc);

        // Operands and valid churn while BUSY must not disturb the captured op
        send(8'h37, 8'h44, 1'b1, 1'b0, acc);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            bus.io_in_valid = 1'b1;
            drive_ops(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end
        bus.io_in_valid = 1'b0;
        wait_result("churn", 8'h7C, 1'b0, acc);

        // Backpressure in DONE, then release with a pending request
        @(posedge clk);
        #1;
        bus.io_out_ready = 1'b0;
        send(8'h21, 8'h13, 1'b0, 1'b0, acc);
        bus.io_in_valid = 1'b1;
        drive_ops(8'h40, 8'h0F, 1'b0, 1'b0);
        bad = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.io_out_valid) begin
                bad = 0;
                break;
            end
        end
        if (bad != 0) check("bp_timeout", 32'd0, 32'd1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_in_ready", {31'd0, bus.io_in_ready}, 32'd0);
            check("bp_valid", {31'd0, bus.io_out_valid}, 32'd1);
            check("bp_sum", {24'd0, bus.io_out_sum}, 32'h34);
            check("bp_cout", {31'd0, bus.io_out_cout}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.io_out_ready = 1'b1;
        @(negedge clk);
        check("b2b_in_ready", {31'd0, bus.io_in_ready}, 32'd1);
        acc = cyc + 1;
        @(posedge clk);
        #1;
        bus.io_in_valid = 1'b0;
        wait_result("b2b", 8'h4F, 1'b0, acc);

        // Reset while idx==2
        send(8'h12, 8'h34, 1'b0, 1'b0, acc);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, bus.io_in_ready}, 32'd1);
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.io_out_valid) bad++;
            @(negedge clk);
        end
        check("rst_no_valid", bad, 0);
        send(8'h01, 8'h01, 1'b0, 1'b0, acc);
        wait_result("after_rst", 8'h02, 1'b0, acc);

`ifdef SERIAL_ADDER_SUB_EN
        send(8'h10, 8'h01, 1'b0, 1'b1, acc);
        wait_result("sub", 8'h0F, 1'b1, acc);
        send(8'h00, 8'h01, 1'b0, 1'b1, acc);
        wait_result("sub_borrow", 8'hFF, 1'b0, acc);
`endif

        // Randomized traffic, backpressure and occasional reset
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            #1;
            reset            = ($urandom_range(0, 99) == 0);
            bus.io_in_valid  = 1'($urandom);
            bus.io_out_ready = ($urandom_range(0, 3) != 0);
`ifdef SERIAL_ADDER_SUB_EN
            drive_ops(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
`else
            drive_ops(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
`endif
        end
        @(posedge clk);
        #1;
        reset            = 1'b0;
        bus.io_in_valid  = 1'b0;
        bus.io_out_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("drain", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
